rsa_cmd_sequencer: RTL and testbench

Hardware host-side sequencer for the Montgomery coprocessor command protocol. It stands in for the ARM and drives the coprocessor's command port (port1), its operand input (bram_din), its result output (bram_dout) and its done port (port2). On a single job request it loads all operands and starts a modular multiplication or exponentiation. It then fetches the result and reports completion. It sits between a PL-side job source (self-test engine, bench or DMA front end) and the coprocessor wrapper.

---
 rtl/rsa_cmd_pkg.sv | 63 ++++++
 rtl/rsa_seq_watchdog.sv | 33 +++
 rtl/rsa_cmd_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_rsa_cmd_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_cmd_pkg.sv
// rsa_cmd_pkg: shared definitions for the Montgomery coprocessor command
// protocol. Holds the nine command codes, the sequencer state enumeration,
// the per-job step tables and the default operand width. The coprocessor
// wrapper imports the same command codes so both sides agree on encoding.
package rsa_cmd_pkg;

  localparam int DATA_W = 512;

  // Command codes driven on port1_din (zero-extended to 32 bits).
  localparam logic [3:0] CMD_READ_OP1   = 4'd0;
  localparam logic [3:0] CMD_READ_OP2   = 4'd1;
  localparam logic [3:0] CMD_READ_OP3   = 4'd2;
  localparam logic [3:0] CMD_READ_OP4   = 4'd3;
  localparam logic [3:0] CMD_READ_OP5   = 4'd4;
  localparam logic [3:0] CMD_START_MULT = 4'd5;
  localparam logic [3:0] CMD_WRITE_MULT = 4'd6;
  localparam logic [3:0] CMD_START_EXP  = 4'd7;
  localparam logic [3:0] CMD_WRITE_EXP  = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_DATA   = 3'd2,
    ST_RESULT = 3'd3,
    ST_ACK    = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } seq_state_e;

  // Step tables, entry 0 is the first command. Padded to 8 entries so the
  // 3-bit step counter can never index outside the table.
  localparam logic [7:0][3:0] MULT_STEPS = {
    4'd0, 4'd0, 4'd0,
    CMD_WRITE_MULT, CMD_START_MULT,
    CMD_READ_OP3, CMD_READ_OP2, CMD_READ_OP1
  };
  localparam logic [7:0][3:0] EXP_STEPS = {
    4'd0,
    CMD_WRITE_EXP, CMD_START_EXP,
    CMD_READ_OP5, CMD_READ_OP4, CMD_READ_OP3, CMD_READ_OP2, CMD_READ_OP1
  };

  localparam logic [2:0] MULT_LAST_STEP = 3'd4;
  localparam logic [2:0] EXP_LAST_STEP  = 3'd6;

  function automatic logic [3:0] step_code(input logic is_exp, input logic [2:0] step);
    return is_exp ? EXP_STEPS[step] : MULT_STEPS[step];
  endfunction

  function automatic logic [2:0] last_step(input logic is_exp);
    return is_exp ? EXP_LAST_STEP : MULT_LAST_STEP;
  endfunction

  function automatic logic is_read_code(input logic [3:0] code);
    return code <= CMD_READ_OP5;
  endfunction

  function automatic logic is_start_code(input logic [3:0] code);
    return (code == CMD_START_MULT) || (code == CMD_START_EXP);
  endfunction

endpackage

// File: rtl/rsa_seq_watchdog.sv
// rsa_seq_watchdog: per-wait timeout counter for the command sequencer.
// Ports:
//   clk, resetn  - clock, synchronous active-low reset
//   clear        - restart the count (sequencer changes state this cycle)
//   count_en     - sequencer is in a state that waits on the coprocessor
//   expired      - count reached TIMEOUT_CYCLES while waiting
module rsa_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] count;

  // Fires in the TIMEOUT_CYCLES-th waiting cycle, so the sequencer leaves
  // after exactly TIMEOUT_CYCLES cycles in one wait state.
  assign expired = count_en && (count >= LIMIT);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/rsa_cmd_sequencer.sv
// rsa_cmd_sequencer: host-side sequencer for the Montgomery coprocessor.
// Accepts one job (multiply: 3 operands, exponentiate: 5 operands), walks
// the command step list over port1, streams operands on bram_din1, fetches
// the result from bram_dout1 and reports job_done (or job_error).
//
// Ports:
//   clk, resetn               clock, synchronous active-low reset
//   job_start/job_exp/op1..5  job request, sampled only when idle
//   job_busy/done/error       job status (done/error are 1-cycle pulses)
//   job_result                last fetched result, held until next job
//   port1_din/valid/read      command port to the coprocessor
//   bram_din1/2/din_valid     operand port (din2 is constant 0)
//   bram_dout1/valid, _read   result port (dout2 side is ignored)
//   port2_valid/read          coprocessor done flag and its acknowledge
//   dbg_state                 current FSM state (seq_state_e encoding)
//
// Handshakes: port1_valid holds until port1_read is seen high, then drops on
// the next cycle. bram_din_valid, bram_dout_read and port2_read are one-cycle
// pulses. port2_valid is level-sensitive and must fall before the next
// command is issued, since the coprocessor's done flag lags its acknowledge.
//
// Build option: define SEQ_TIMEOUT_EN to add a watchdog that aborts any wait
// longer than TIMEOUT_CYCLES with a job_error pulse. Without it the
// sequencer waits indefinitely and job_error stays 0.
module rsa_cmd_sequencer #(
  parameter int          DATA_W         = rsa_cmd_pkg::DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              job_start,
  input  logic              job_exp,
  input  logic [DATA_W-1:0] job_op1,
  input  logic [DATA_W-1:0] job_op2,
  input  logic [DATA_W-1:0] job_op3,
  input  logic [DATA_W-1:0] job_op4,
  input  logic [DATA_W-1:0] job_op5,
  output logic              job_busy,
  output logic              job_done,
  output logic              job_error,
  output logic [DATA_W-1:0] job_result,
  output logic [31:0]       port1_din,
  output logic              port1_valid,
  input  logic              port1_read,
  output logic [DATA_W-1:0] bram_din1,
  output logic [DATA_W-1:0] bram_din2,
  output logic              bram_din_valid,
  input  logic [DATA_W-1:0] bram_dout1,
  input  logic              bram_dout1_valid,
  input  logic [DATA_W-1:0] bram_dout2,
  input  logic              bram_dout2_valid,
  output logic              bram_dout_read,
  input  logic              port2_valid,
  output logic              port2_read,
  output logic [2:0]        dbg_state
);
  import rsa_cmd_pkg::*;

  seq_state_e        state, state_next;
  logic [2:0]        step, step_next;
  logic              exp_q, exp_next;
  logic [DATA_W-1:0] ops [5];
  logic [3:0]        cur_code, next_code;
  logic              wd_expired;
  logic              take_result, take_done;

  assign dbg_state = state;
  assign bram_din2 = '0;

  logic unused;
  assign unused = &{1'b0, bram_dout2, bram_dout2_valid, (TIMEOUT_CYCLES != 0)};

  always_comb begin
    cur_code    = step_code(exp_q, step);
    state_next  = state;
    step_next   = step;
    exp_next    = exp_q;
    take_result = 1'b0;
    take_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (job_start) begin
          state_next = ST_CMD;
          step_next  = 3'd0;
          exp_next   = job_exp;
        end
      end
      ST_CMD: begin
        if (port1_read) begin
          if (is_read_code(cur_code))       state_next = ST_DATA;
          else if (is_start_code(cur_code)) state_next = ST_ACK;
          else                              state_next = ST_RESULT;
        end
      end
      ST_DATA: state_next = ST_ACK;
      ST_RESULT: begin
        if (bram_dout1_valid) begin
          state_next  = ST_ACK;
          take_result = 1'b1;
        end
      end
      ST_ACK: begin
        if (port2_valid) begin
          state_next = ST_DRAIN;
          take_done  = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Wait for the lagging done flag to fall before moving on.
        if (!port2_valid) begin
          if (step == last_step(exp_q)) begin
            state_next = ST_DONE;
          end else begin
            step_next  = step + 3'd1;
            state_next = ST_CMD;
          end
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_ERROR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // A watchdog abort overrides any transition and suppresses the
    // result latch and acknowledges of this cycle.
    if (wd_expired) begin
      state_next  = ST_ERROR;
      take_result = 1'b0;
      take_done   = 1'b0;
    end
    next_code = step_code(exp_next, step_next);
  end

  // State plus all protocol outputs registered from the next state, so each
  // output is a clean flop aligned with the state it belongs to.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      step           <= 3'd0;
      exp_q          <= 1'b0;
      job_busy       <= 1'b0;
      job_done       <= 1'b0;
      job_error      <= 1'b0;
      job_result     <= '0;
      port1_din      <= '0;
      port1_valid    <= 1'b0;
      bram_din1      <= '0;
      bram_din_valid <= 1'b0;
      bram_dout_read <= 1'b0;
      port2_read     <= 1'b0;
    end else begin
      state          <= state_next;
      step           <= step_next;
      exp_q          <= exp_next;
      job_busy       <= state_next inside {ST_CMD, ST_DATA, ST_RESULT, ST_ACK, ST_DRAIN};
      job_done       <= (state_next == ST_DONE);
      job_error      <= (state_next == ST_ERROR);
      port1_valid    <= (state_next == ST_CMD);
      port1_din      <= (state_next == ST_CMD) ? {28'd0, next_code} : 32'd0;
      // DATA is only entered from a READ command, whose code is the operand index.
      bram_din_valid <= (state_next == ST_DATA);
      bram_din1      <= (state_next == ST_DATA) ? ops[cur_code[2:0]] : '0;
      bram_dout_read <= take_result;
      port2_read     <= take_done;
      if (take_result) begin
        job_result <= bram_dout1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && job_start) begin
      ops[0] <= job_op1;
      ops[1] <= job_op2;
      ops[2] <= job_op3;
      ops[3] <= job_op4;
      ops[4] <= job_op5;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic wd_clear, wd_count_en;
  assign wd_count_en = state inside {ST_CMD, ST_RESULT, ST_ACK, ST_DRAIN};
  assign wd_clear    = (state_next != state);

  rsa_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (wd_clear),
    .count_en(wd_count_en),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_cmd_sequencer.sv
// tb_rsa_cmd_sequencer: directed + randomized bench for rsa_cmd_sequencer.
// A behavioural coprocessor responder answers commands; each job's expected
// command list, operand stream and result come from the job description.
// Define SEQ_TIMEOUT_EN for both bench and design to cover the watchdog.
module tb_rsa_cmd_sequencer;
  localparam int DW = 512;
`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1 << 20;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          job_start, job_exp;
  logic [DW-1:0] job_op1, job_op2, job_op3, job_op4, job_op5;
  logic          job_busy, job_done, job_error;
  logic [DW-1:0] job_result;
  logic [31:0]   port1_din;
  logic          port1_valid, port1_read;
  logic [DW-1:0] bram_din1, bram_din2;
  logic          bram_din_valid;
  logic [DW-1:0] bram_dout1, bram_dout2;
  logic          bram_dout1_valid, bram_dout2_valid;
  logic          bram_dout_read;
  logic          port2_valid, port2_read;
  logic [2:0]    dbg_state;

  rsa_cmd_sequencer #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .job_start(job_start), .job_exp(job_exp),
    .job_op1(job_op1), .job_op2(job_op2), .job_op3(job_op3),
    .job_op4(job_op4), .job_op5(job_op5),
    .job_busy(job_busy), .job_done(job_done), .job_error(job_error),
    .job_result(job_result),
    .port1_din(port1_din), .port1_valid(port1_valid), .port1_read(port1_read),
    .bram_din1(bram_din1), .bram_din2(bram_din2), .bram_din_valid(bram_din_valid),
    .bram_dout1(bram_dout1), .bram_dout1_valid(bram_dout1_valid),
    .bram_dout2(bram_dout2), .bram_dout2_valid(bram_dout2_valid),
    .bram_dout_read(bram_dout_read),
    .port2_valid(port2_valid), .port2_read(port2_read),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [3:0]    cmd_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] din_q[$];
  logic [DW-1:0] ops [5];
  logic [DW-1:0] resp_result = '0;
  int  extra_hold = 0;
  bit  stall_after_start = 0;
  int  done_dly = -1, rslt_dly = -1, drop_cnt = -1;
  int  done_cnt = 0, err_cnt = 0, err_total = 0, dread_cnt = 0, p2r_cnt = 0;
  int  cyc = 0, start_cycle = 0, err_cycle = 0;
  logic prev_p1v = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {job_busy, job_done, job_error, port1_valid,
                          bram_din_valid, bram_dout_read, port2_read}, '0);
    check({tag, "_p1din"}, port1_din, '0);
    check({tag, "_result"}, job_result, '0);
    check({tag, "_din1"}, bram_din1, '0);
    check({tag, "_din2"}, bram_din2, '0);
  endtask

  // ---------------- coprocessor responder + protocol monitor ----------------
  initial begin
    port1_read = 1'b0;
    bram_dout1 = '0;
    bram_dout1_valid = 1'b0;
    port2_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!resetn) begin
        port1_read = 1'b0; bram_dout1_valid = 1'b0; port2_valid = 1'b0;
        done_dly = -1; rslt_dly = -1; drop_cnt = -1; prev_p1v = 1'b0;
        continue;
      end
      if (job_done) done_cnt++;
      if (job_error) begin err_cnt++; err_total++; err_cycle = cyc; end
      if (bram_dout_read) dread_cnt++;
      if (port2_read) begin
        p2r_cnt++;
        check("no_overlap_p2read", {port1_valid, bram_din_valid}, '0);
      end
      // A new command may only follow a done flag that has already fallen.
      if (port1_valid && !prev_p1v) check("cmd_after_drain", port2_valid, '0);
      prev_p1v = port1_valid;
      // Done flag lags the acknowledge by one cycle, plus optional hold.
      if (drop_cnt == 0) begin port2_valid = 1'b0; drop_cnt = -1; end
      else if (drop_cnt > 0) drop_cnt--;
      if (port2_read) drop_cnt = extra_hold;
      port1_read = port1_valid;
      if (port1_valid) begin
        cmd_q.push_back(port1_din[3:0]);
        if (port1_din == 32'd5 || port1_din == 32'd7) begin
          start_cycle = cyc;
          if (!stall_after_start) done_dly = $urandom_range(0, 3);
        end else if (port1_din == 32'd6 || port1_din == 32'd8) begin
          rslt_dly = $urandom_range(0, 3);
        end
      end
      if (bram_din_valid) begin
        din_q.push_back(bram_din1);
        done_dly = $urandom_range(0, 3);
      end
      if (bram_dout_read) begin
        bram_dout1_valid = 1'b0;
        bram_dout1 = '0;
        done_dly = $urandom_range(0, 3);
      end
      if (rslt_dly == 0) begin
        bram_dout1_valid = 1'b1; bram_dout1 = resp_result; rslt_dly = -1;
      end else if (rslt_dly > 0) rslt_dly--;
      if (done_dly == 0) begin port2_valid = 1'b1; done_dly = -1; end
      else if (done_dly > 0) done_dly--;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_traces();
    cmd_q.delete(); din_q.delete();
    done_cnt = 0; err_cnt = 0; dread_cnt = 0; p2r_cnt = 0;
  endtask

  task automatic pulse_start(input logic e);
    job_exp = e;
    job_op1 = ops[0]; job_op2 = ops[1]; job_op3 = ops[2];
    job_op4 = ops[3]; job_op5 = ops[4];
    job_start = 1'b1;
    @(posedge clk); #2;
    job_start = 1'b0;
    // Scramble the operand inputs so only captured values can appear.
    job_op1 = ~job_op1; job_op2 = ~job_op2; job_op3 = ~job_op3;
    job_op4 = ~job_op4; job_op5 = ~job_op5;
    job_exp = ~e;
  endtask

  task automatic run_job(input logic e, input logic [DW-1:0] res, input int hold,
                         input bit poke_busy, input string tag);
    logic [3:0] exp_cmds[$];
    int n;
    // Reference: operands in order, then the START/WRITE pair for the job type.
    exp_cmds.delete(); exp_q.delete();
    for (int i = 0; i < (e ? 5 : 3); i++) begin
      exp_cmds.push_back(4'(i));
      exp_q.push_back(ops[i]);
    end
    exp_cmds.push_back(e ? 4'd7 : 4'd5);
    exp_cmds.push_back(e ? 4'd8 : 4'd6);
    clear_traces();
    resp_result = res;
    extra_hold = hold;
    pulse_start(e);
    check({tag, "_busy"}, job_busy, 1'b1);
    if (poke_busy) begin
      repeat (3) begin @(posedge clk); #2; end
      job_start = 1'b1;
      @(posedge clk); #2;
      job_start = 1'b0;
    end
    n = 0;
    while (!job_done && !job_error && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_finished_in_time"}, (n < 3000), 1'b1);
    repeat (20) begin @(posedge clk); #2; end
    check({tag, "_ncmd"}, cmd_q.size(), exp_cmds.size());
    for (int i = 0; i < exp_cmds.size(); i++)
      if (i < cmd_q.size()) check($sformatf("%s_cmd%0d", tag, i), cmd_q[i], exp_cmds[i]);
    check({tag, "_ndin"}, din_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < din_q.size()) check($sformatf("%s_din%0d", tag, i), din_q[i], exp_q[i]);
    check({tag, "_result"}, job_result, res);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_dout_read_cnt"}, dread_cnt, 1);
    check({tag, "_port2_read_cnt"}, p2r_cnt, exp_cmds.size());
    check({tag, "_idle_busy"}, job_busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] last_res;
    int n;
    resetn = 1'b0; job_start = 1'b0; job_exp = 1'b0;
    job_op1 = '0; job_op2 = '0; job_op3 = '0; job_op4 = '0; job_op5 = '0;
    bram_dout2 = '0; bram_dout2_valid = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    check_all_zero("reset");
    resetn = 1'b1;
    repeat (2) begin @(posedge clk); #2; end

    // Multiply 5*7 mod 13, responder returns 9.
    ops[0] = 5; ops[1] = 7; ops[2] = 13; ops[3] = '0; ops[4] = '0;
    run_job(1'b0, 9, 0, 1'b0, "mult");

    // Exponentiate with operands 1..5.
    for (int i = 0; i < 5; i++) ops[i] = DW'(i + 1);
    run_job(1'b1, rand_wide(), 0, 1'b0, "exp");

    // Done flag held one extra cycle after the acknowledge.
    ops[0] = rand_wide(); ops[1] = rand_wide(); ops[2] = rand_wide();
    run_job(1'b0, rand_wide(), 1, 1'b0, "hold");

    // job_start while busy must not disturb the command trace.
    run_job(1'b1, rand_wide(), 0, 1'b1, "poke");

    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 5; i++) ops[i] = rand_wide();
      run_job(1'($urandom_range(0, 1)), rand_wide(), $urandom_range(0, 2), 1'b0,
              $sformatf("rnd%0d", j));
    end

    // Reset during exponentiate step 3 (READ_OP4).
    for (int i = 0; i < 5; i++) ops[i] = DW'(i + 1);
    clear_traces();
    pulse_start(1'b1);
    n = 0;
    while (!(port1_valid && port1_din == 32'd3) && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    check("midreset_reached_step3", (n < 500), 1'b1);
    resetn = 1'b0;
    @(posedge clk); #2;
    check_all_zero("midreset");
    @(posedge clk); #2;
    resetn = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    ops[0] = 11; ops[1] = 3; ops[2] = 17;
    run_job(1'b0, 16, 0, 1'b0, "after_reset");
    last_res = 16;

`ifdef SEQ_TIMEOUT_EN
    // Coprocessor never signals done after START: expect a watchdog abort
    // after TO cycles in ACK, no job_done and an unchanged result.
    clear_traces();
    stall_after_start = 1'b1;
    pulse_start(1'b0);
    n = 0;
    while (!job_done && !job_error && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    check("timeout_seen", (n < 1000), 1'b1);
    repeat (10) begin @(posedge clk); #2; end
    check("timeout_err_cnt", err_cnt, 1);
    check("timeout_done_cnt", done_cnt, 0);
    check("timeout_ack_cycles", err_cycle - start_cycle, TO + 1);
    check("timeout_result_kept", job_result, last_res);
    check("timeout_idle_busy", job_busy, 1'b0);
    stall_after_start = 1'b0;
    err_total = 0;
    run_job(1'b0, rand_wide(), 0, 1'b0, "after_timeout");
`else
    check("no_error_without_watchdog", err_total, 0);
    check("last_result_held", job_result, last_res);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
